// File: rtl/llm_chi_slv_mo.sv
// Multi-outstanding CHI-H slave front end: tagged transaction table, out-of-order downstream returns.
// Optional build macro LLM_CHI_SLV_MO_TIMEOUT_EN adds per-entry age counters and error-11 timeouts.
module llm_chi_slv_mo #(
   parameter int ADDR_W    = 48,
   parameter int DATA_W    = 512,
   parameter int PLD_W     = 64,
   parameter int PRI_W     = 3,
   parameter int TXN_DEPTH = 8,
   parameter int TAG_W     = $clog2(TXN_DEPTH),
   parameter int TS_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        chi_h_version,
   input  logic [TS_W-1:0]   timeout_limit,
   input  logic              rn_chi_req_valid,
   output logic              rn_chi_req_ready,
   input  logic [ADDR_W-1:0] rn_chi_req_addr,
   input  logic [DATA_W-1:0] rn_chi_req_data,
   input  logic [7:0]        rn_chi_req_size,
   input  logic [7:0]        rn_chi_req_txnid,
   input  logic [PLD_W-1:0]  rn_chi_req_pld,
   output logic              rn_chi_resp_valid,
   input  logic              rn_chi_resp_ready,
   output logic [DATA_W-1:0] rn_chi_resp_data,
   output logic [7:0]        rn_chi_resp_txnid,
   output logic [1:0]        rn_chi_resp_error,
   output logic [31:0]       rn_chi_resp_pld,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [DATA_W-1:0] cmd_data,
   output logic [7:0]        cmd_size,
   output logic [3:0]        cmd_type,
   output logic [31:0]       cmd_pld,
   output logic [PRI_W-1:0]  cmd_priority,
   output logic [TAG_W-1:0]  cmd_tag,
   input  logic              rsp_valid,
   output logic              rsp_ready,
   input  logic [TAG_W-1:0]  rsp_tag,
   input  logic [DATA_W-1:0] rsp_data,
   input  logic              rsp_error,
   input  logic [31:0]       rsp_pld,
   output logic [TAG_W:0]    outstanding_cnt,
   output logic [TS_W-1:0]   snp_resp_latency,
   output logic [15:0]       stale_rsp_cnt
);

   typedef enum logic [2:0] {
      ST_FREE  = 3'd0,
      ST_PEND  = 3'd1,
      ST_ILL   = 3'd2,
      ST_TIMED = 3'd3,
      ST_RESP  = 3'd4
   } ent_state_e;

   localparam logic [TAG_W:0]  CNT_ONE = {{TAG_W{1'b0}}, 1'b1};
   localparam logic [TS_W-1:0] TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};

   function automatic logic [3:0] map_type(input logic [7:0] t);
      case (t)
         8'h01:   map_type = 4'h1;
         8'h02:   map_type = 4'h2;
         8'h03:   map_type = 4'h4;
         8'h04:   map_type = 4'h8;
         8'h05:   map_type = 4'h9;
         8'h06:   map_type = 4'hA;
         default: map_type = 4'h0;
      endcase
   endfunction

   ent_state_e        state_r [TXN_DEPTH];
   logic [7:0]        txnid_r [TXN_DEPTH];
   logic              snp_r   [TXN_DEPTH];
   logic [TS_W-1:0]   stamp_r [TXN_DEPTH];
   logic [TS_W-1:0]   ts_r;
   logic [TAG_W:0]    cnt_r;
   logic [15:0]       stale_r;
   logic [TS_W-1:0]   snp_lat_r;

   logic              cmd_valid_r;
   logic [ADDR_W-1:0] cmd_addr_r;
   logic [DATA_W-1:0] cmd_data_r;
   logic [7:0]        cmd_size_r;
   logic [3:0]        cmd_type_r;
   logic [31:0]       cmd_pld_r;
   logic [PRI_W-1:0]  cmd_pri_r;
   logic [TAG_W-1:0]  cmd_tag_r;

   logic              resp_valid_r;
   logic [DATA_W-1:0] resp_data_r;
   logic [7:0]        resp_txnid_r;
   logic [1:0]        resp_err_r;
   logic [31:0]       resp_pld_r;
   logic [TAG_W-1:0]  resp_tag_r;

   logic              free_found_s, timed_found_s, ill_found_s;
   logic [TAG_W-1:0]  free_idx_s, timed_idx_s, ill_idx_s;
   logic              accept_s, req_legal_s, resp_hs_s, load_ok_s;
   logic              rsp_pend_s, rsp_hs_s, rsp_live_s, rsp_stale_s;
   logic [3:0]        req_type_s;
   logic [31:0]       req_pld_s;
   logic [PRI_W-1:0]  req_pri_s;
   logic              load_s;
   logic [TAG_W-1:0]  load_tag_s;
   logic [1:0]        load_err_s;
   logic [DATA_W-1:0] load_data_s;
   logic [31:0]       load_pld_s;

   // Lowest-index search over the table for free, illegal and (optionally) timed entries.
   always_comb begin
      free_found_s = 1'b0;
      free_idx_s   = '0;
      ill_found_s  = 1'b0;
      ill_idx_s    = '0;
      for (int i = TXN_DEPTH - 1; i >= 0; i--) begin
         free_found_s = free_found_s | (state_r[i] == ST_FREE);
         free_idx_s   = (state_r[i] == ST_FREE) ? TAG_W'(i) : free_idx_s;
         ill_found_s  = ill_found_s | (state_r[i] == ST_ILL);
         ill_idx_s    = (state_r[i] == ST_ILL) ? TAG_W'(i) : ill_idx_s;
      end
   end

`ifdef LLM_CHI_SLV_MO_TIMEOUT_EN
   logic [TS_W-1:0] age_r [TXN_DEPTH];

   // Lowest-index search for entries that have timed out.
   always_comb begin
      timed_found_s = 1'b0;
      timed_idx_s   = '0;
      for (int i = TXN_DEPTH - 1; i >= 0; i--) begin
         timed_found_s = timed_found_s | (state_r[i] == ST_TIMED);
         timed_idx_s   = (state_r[i] == ST_TIMED) ? TAG_W'(i) : timed_idx_s;
      end
   end

   // Per-entry age: cleared on allocation, counts while waiting for a downstream rsp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TXN_DEPTH; i++) age_r[i] <= '0;
      end else begin
         for (int i = 0; i < TXN_DEPTH; i++) begin
            if (accept_s && free_idx_s == TAG_W'(i)) age_r[i] <= '0;
            else if (state_r[i] == ST_PEND)          age_r[i] <= age_r[i] + TS_ONE;
            else                                      age_r[i] <= age_r[i];
         end
      end
   end
`else
   logic unused_timeout_s;
   assign unused_timeout_s = ^timeout_limit;
   assign timed_found_s    = 1'b0;
   assign timed_idx_s      = '0;
`endif

   // Request decode: legality, cmd type and version-dependent pld/priority fields.
   always_comb begin
      req_type_s  = map_type(rn_chi_req_pld[31:24]);
      req_legal_s = (req_type_s != 4'h0);
      case (chi_h_version)
         2'b01: begin
            req_pld_s = rn_chi_req_pld[31:0];
            req_pri_s = PRI_W'(rn_chi_req_pld[7:5]);
         end
         2'b10: begin
            req_pld_s = rn_chi_req_pld[63:32];
            req_pri_s = PRI_W'(rn_chi_req_pld[11:9]);
         end
         default: begin
            req_pld_s = 32'h0000_0000;
            req_pri_s = '0;
         end
      endcase
   end

   assign rn_chi_req_ready = free_found_s & (~cmd_valid_r | cmd_ready);
   assign accept_s         = rn_chi_req_valid & rn_chi_req_ready;
   assign resp_hs_s        = resp_valid_r & rn_chi_resp_ready;
   assign load_ok_s        = ~resp_valid_r | rn_chi_resp_ready;
   assign rsp_pend_s       = (state_r[rsp_tag] == ST_PEND);
   // Stale rsps are always swallowed, even while the response register is blocked.
   assign rsp_ready        = load_ok_s | ~rsp_pend_s;
   assign rsp_hs_s         = rsp_valid & rsp_ready;
   assign rsp_live_s       = rsp_hs_s & rsp_pend_s;
   assign rsp_stale_s      = rsp_hs_s & ~rsp_pend_s;

   // Response-register source select: downstream rsp, then timed-out, then illegal entries.
   always_comb begin
      load_s      = 1'b0;
      load_tag_s  = '0;
      load_err_s  = 2'b00;
      load_data_s = '0;
      load_pld_s  = 32'h0000_0000;
      if (rsp_live_s) begin
         load_s      = 1'b1;
         load_tag_s  = rsp_tag;
         load_err_s  = {1'b0, rsp_error};
         load_data_s = rsp_data;
         load_pld_s  = rsp_pld;
      end else if (load_ok_s && timed_found_s) begin
         load_s     = 1'b1;
         load_tag_s = timed_idx_s;
         load_err_s = 2'b11;
      end else if (load_ok_s && ill_found_s) begin
         load_s     = 1'b1;
         load_tag_s = ill_idx_s;
         load_err_s = 2'b10;
      end else begin
         load_s = 1'b0;
      end
   end

   // Transaction table state; a free on the RN handshake only takes effect at the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TXN_DEPTH; i++) begin
            state_r[i] <= ST_FREE;
            txnid_r[i] <= 8'h00;
            snp_r[i]   <= 1'b0;
            stamp_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < TXN_DEPTH; i++) begin
`ifdef LLM_CHI_SLV_MO_TIMEOUT_EN
            if (state_r[i] == ST_PEND && timeout_limit != '0 &&
                (age_r[i] + TS_ONE) == timeout_limit)
               state_r[i] <= ST_TIMED;
`endif
            if (load_s && load_tag_s == TAG_W'(i))
               state_r[i] <= ST_RESP;
            if (resp_hs_s && resp_tag_r == TAG_W'(i))
               state_r[i] <= ST_FREE;
            if (accept_s && free_idx_s == TAG_W'(i)) begin
               state_r[i] <= req_legal_s ? ST_PEND : ST_ILL;
               txnid_r[i] <= rn_chi_req_txnid;
               snp_r[i]   <= (rn_chi_req_pld[31:24] == 8'h06);
               stamp_r[i] <= ts_r;
            end
         end
      end
   end

   // Forwarded command register, held until cmd_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid_r <= 1'b0;
         cmd_addr_r  <= '0;
         cmd_data_r  <= '0;
         cmd_size_r  <= 8'h00;
         cmd_type_r  <= 4'h0;
         cmd_pld_r   <= 32'h0000_0000;
         cmd_pri_r   <= '0;
         cmd_tag_r   <= '0;
      end else if (accept_s && req_legal_s) begin
         cmd_valid_r <= 1'b1;
         cmd_addr_r  <= rn_chi_req_addr;
         cmd_data_r  <= rn_chi_req_data;
         cmd_size_r  <= rn_chi_req_size;
         cmd_type_r  <= req_type_s;
         cmd_pld_r   <= req_pld_s;
         cmd_pri_r   <= req_pri_s;
         cmd_tag_r   <= free_idx_s;
      end else if (cmd_ready) begin
         cmd_valid_r <= 1'b0;
      end
   end

   // RN response register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_r <= 1'b0;
         resp_data_r  <= '0;
         resp_txnid_r <= 8'h00;
         resp_err_r   <= 2'b00;
         resp_pld_r   <= 32'h0000_0000;
         resp_tag_r   <= '0;
      end else if (load_s) begin
         resp_valid_r <= 1'b1;
         resp_data_r  <= load_data_s;
         resp_txnid_r <= txnid_r[load_tag_s];
         resp_err_r   <= load_err_s;
         resp_pld_r   <= load_pld_s;
         resp_tag_r   <= load_tag_s;
      end else if (resp_hs_s) begin
         resp_valid_r <= 1'b0;
      end
   end

   // Timestamp, occupancy, stale counter and SNP latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_r      <= '0;
         cnt_r     <= '0;
         stale_r   <= 16'h0000;
         snp_lat_r <= '0;
      end else begin
         ts_r <= ts_r + TS_ONE;
         case ({accept_s, resp_hs_s})
            2'b10:   cnt_r <= cnt_r + CNT_ONE;
            2'b01:   cnt_r <= cnt_r - CNT_ONE;
            default: cnt_r <= cnt_r;
         endcase
         if (rsp_stale_s && stale_r != 16'hFFFF)
            stale_r <= stale_r + 16'h0001;
         if (rsp_live_s && snp_r[rsp_tag])
            snp_lat_r <= ts_r - stamp_r[rsp_tag];
      end
   end

   assign cmd_valid         = cmd_valid_r;
   assign cmd_addr          = cmd_addr_r;
   assign cmd_data          = cmd_data_r;
   assign cmd_size          = cmd_size_r;
   assign cmd_type          = cmd_type_r;
   assign cmd_pld           = cmd_pld_r;
   assign cmd_priority      = cmd_pri_r;
   assign cmd_tag           = cmd_tag_r;
   assign rn_chi_resp_valid = resp_valid_r;
   assign rn_chi_resp_data  = resp_data_r;
   assign rn_chi_resp_txnid = resp_txnid_r;
   assign rn_chi_resp_error = resp_err_r;
   assign rn_chi_resp_pld   = resp_pld_r;
   assign outstanding_cnt   = cnt_r;
   assign snp_resp_latency  = snp_lat_r;
   assign stale_rsp_cnt     = stale_r;

endmodule
